// File: rtl/pokey_kbd_irq.sv
// POKEY keyboard front-end: debounce, KBCODE/SKSTAT bits, keyboard IRQ.
// Optional BREAK-key IRQ when KBD_BREAK_IRQ_EN is defined.
module pokey_kbd_irq #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic       clk179,
    input  logic       rst,
    input  logic       kbd_en,
    input  logic [3:0] keycode_in,
    input  logic       key_down,
    input  logic       shift_L,
    input  logic       ctrl_L,
    input  logic       irqen_kbd,
    input  logic       skres_wr,
`ifdef KBD_BREAK_IRQ_EN
    input  logic       break_L,
    input  logic       irqen_brk,
    output logic       irqst_brk_L,
`endif
    output logic [7:0] KBCODE,
    output logic       irqst_kbd_L,
    output logic [2:0] skstat_kbd,
    output logic       key_event
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_e;

    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYC - 1);
    localparam bit         ONE  = (DEBOUNCE_CYC == 1);

    // Counter has seen enough stable cycles once this edge is taken.
    function automatic logic reached(input logic [7:0] c);
        return ({1'b0, c} + 9'd1) >= {1'b0, LAST};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] cand_q, cand_d;
    logic [7:0] kbcode_q, kbcode_d;
    logic       irq_q, irq_d;
    logic       ovr_q, ovr_d;
    logic       kd_q, kd_d;
    logic       shift_q;
    logic       event_q;
    logic       accept;
    logic       recap;

    // Debounce FSM next state; recapture shared by all states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        recap   = 1'b0;
        if (!kbd_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (key_down) recap = 1'b1;
                end
                PRESS_DB: begin
                    if (!key_down) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (keycode_in != cand_q) begin
                        recap = 1'b1;
                    end else if (reached(cnt_q)) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        accept  = 1'b1;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                HELD: begin
                    if (!key_down) begin
                        cnt_d   = '0;
                        state_d = ONE ? IDLE : RELEASE_DB;
                    end else if (keycode_in != cand_q) begin
                        recap = 1'b1;
                    end
                end
                RELEASE_DB: begin
                    if (!key_down) begin
                        if (reached(cnt_q)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = sat_inc(cnt_q);
                        end
                    end else if (keycode_in == cand_q) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        recap = 1'b1;
                    end
                end
            endcase
            if (recap) begin
                cand_d = keycode_in;
                cnt_d  = '0;
                if (ONE) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    state_d = PRESS_DB;
                end
            end
        end
    end

    // Register-visible results of an accept, IRQ and overrun.
    always_comb begin
        kbcode_d = kbcode_q;
        irq_d    = irq_q;
        ovr_d    = ovr_q;
        kd_d     = kd_q;
        if (state_d == IDLE) begin
            kd_d = 1'b1;
        end else if (accept) begin
            kd_d = 1'b0;
        end
        if (accept) begin
            kbcode_d = {~ctrl_L, ~shift_L, 2'b00, cand_d};
        end
        if (skres_wr) begin
            ovr_d = 1'b1;
        end
        if (accept && irqen_kbd) begin
            if (!irq_q) ovr_d = 1'b0;
            irq_d = 1'b0;
        end
        if (!irqen_kbd) begin
            irq_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk179) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cand_q   <= '0;
            kbcode_q <= '0;
            irq_q    <= 1'b1;
            ovr_q    <= 1'b1;
            kd_q     <= 1'b1;
            shift_q  <= 1'b1;
            event_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            kbcode_q <= kbcode_d;
            irq_q    <= irq_d;
            ovr_q    <= ovr_d;
            kd_q     <= kd_d;
            shift_q  <= shift_L;
            event_q  <= accept;
        end
    end

    assign KBCODE      = kbcode_q;
    assign irqst_kbd_L = irq_q;
    assign skstat_kbd  = {ovr_q, shift_q, kd_q};
    assign key_event   = event_q;

`ifdef KBD_BREAK_IRQ_EN
    logic       brk_prev_q, brk_prev_d;
    logic       brk_run_q, brk_run_d;
    logic [7:0] brk_cnt_q, brk_cnt_d;
    logic       brk_irq_q, brk_irq_d;
    logic       brk_hit;

    // BREAK falling edge must hold low for the debounce window.
    always_comb begin
        brk_prev_d = break_L;
        brk_run_d  = brk_run_q;
        brk_cnt_d  = brk_cnt_q;
        brk_hit    = 1'b0;
        if (brk_prev_q && !break_L) begin
            brk_cnt_d = '0;
            if (ONE) begin
                brk_hit   = 1'b1;
                brk_run_d = 1'b0;
            end else begin
                brk_run_d = 1'b1;
            end
        end else if (brk_run_q) begin
            if (break_L) begin
                brk_run_d = 1'b0;
            end else if (reached(brk_cnt_q)) begin
                brk_hit   = 1'b1;
                brk_run_d = 1'b0;
            end else begin
                brk_cnt_d = sat_inc(brk_cnt_q);
            end
        end
        brk_irq_d = brk_irq_q;
        if (brk_hit) brk_irq_d = 1'b0;
        if (!irqen_brk) brk_irq_d = 1'b1;
    end

    // BREAK debounce and IRQ registers.
    always_ff @(posedge clk179) begin
        if (rst) begin
            brk_prev_q <= 1'b1;
            brk_run_q  <= 1'b0;
            brk_cnt_q  <= '0;
            brk_irq_q  <= 1'b1;
        end else begin
            brk_prev_q <= brk_prev_d;
            brk_run_q  <= brk_run_d;
            brk_cnt_q  <= brk_cnt_d;
            brk_irq_q  <= brk_irq_d;
        end
    end

    assign irqst_brk_L = brk_irq_q;
`endif

endmodule
